io_fifo_rr_arbiter: RTL and testbench

//  Shares one io_generic_fifo write port between N_CH uDMA requesters using round-robin arbitration with burst lock.

---
 rtl/io_fifo_rr_arbiter_if.sv | 36 +++
 rtl/io_fifo_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_io_fifo_rr_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/io_fifo_rr_arbiter_if.sv
// io_fifo_rr_arbiter_if
//  Bundles the arbiter's request side (N_CH channels) and its registered
//  output side (toward the shared FIFO write port).
//  slave  : arbiter view (consumes requests, produces output word)
//  master : environment view (drives requests, accepts output word)
//  Signals:
//   ch_valid_i  per-channel request valid
//   ch_data_i   per-channel payload, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   ch_ready_o  per-channel accept, one-hot or zero
//   out_valid_o registered output valid
//   out_data_o  registered output payload
//   out_id_o    source channel of out_data_o
//   out_ready_i downstream accept
interface io_fifo_rr_arbiter_if #(
   parameter int N_CH       = 4,
   parameter int DATA_WIDTH = 32,
   parameter int LOG_N_CH   = $clog2(N_CH)
);
   logic [N_CH-1:0]            ch_valid_i;
   logic [N_CH*DATA_WIDTH-1:0] ch_data_i;
   logic [N_CH-1:0]            ch_ready_o;
   logic                       out_valid_o;
   logic [DATA_WIDTH-1:0]      out_data_o;
   logic [LOG_N_CH-1:0]        out_id_o;
   logic                       out_ready_i;

   modport slave (
      input  ch_valid_i, ch_data_i, out_ready_i,
      output ch_ready_o, out_valid_o, out_data_o, out_id_o
   );

   modport master (
      output ch_valid_i, ch_data_i, out_ready_i,
      input  ch_ready_o, out_valid_o, out_data_o, out_id_o
   );
endinterface

// File: rtl/io_fifo_rr_arbiter.sv
// io_fifo_rr_arbiter
//  Shares one FIFO write port between N_CH requesters. Round-robin
//  arbitration with a burst lock of up to BURST_LEN beats per owner.
//  Each accepted word is tagged with its channel ID and held in a
//  one-entry output register.
//  Ports:
//   clk_i   clock (rising edge)
//   rst_i   synchronous reset, active-high (priority over clr_i)
//   clr_i   synchronous clear, same effect as reset
//   busy_o  high while a burst is open or an output word is pending
//   bus     io_fifo_rr_arbiter_if.slave (request + output handshakes)
module io_fifo_rr_arbiter #(
   parameter int N_CH       = 4,
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 4,
   parameter int LOG_N_CH   = $clog2(N_CH)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clr_i,
   output logic                 busy_o,
   io_fifo_rr_arbiter_if.slave  bus
);
   localparam int              CW = $clog2(BURST_LEN + 1);
   localparam logic [CW-1:0]   BL = CW'(BURST_LEN);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                r_state, w_state_nxt;
   logic [LOG_N_CH-1:0]   r_owner, w_owner_nxt;
   logic [CW-1:0]         r_beat_cnt, w_beat_cnt_nxt;

   logic                  r_out_valid;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic [LOG_N_CH-1:0]   r_out_id;

   logic                  w_slot_free, w_hold, w_grant, w_xfer;
   logic [LOG_N_CH-1:0]   w_sel;
   logic [N_CH-1:0]       w_ch_ready;

   assign w_slot_free = !r_out_valid || bus.out_ready_i;

   // Burst owner keeps the grant while it still has beats left and is valid.
   assign w_hold = (r_state == BURST) && bus.ch_valid_i[r_owner] && (r_beat_cnt < BL);

   // Rotating priority scan starting just after the owner; owner itself last.
   always_comb begin
      int idx;
      w_grant = 1'b0;
      w_sel   = '0;
      idx     = 0;
      if (w_hold) begin
         w_grant = 1'b1;
         w_sel   = r_owner;
      end else begin
         for (int i = 1; i <= N_CH; i++) begin
            idx = int'(r_owner) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!w_grant && bus.ch_valid_i[idx]) begin
               w_grant = 1'b1;
               w_sel   = LOG_N_CH'(idx);
            end
         end
      end
   end

   assign w_xfer = |w_ch_ready;

   // FSM: state register
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         r_state    <= IDLE;
         r_owner    <= LOG_N_CH'(N_CH - 1);
         r_beat_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_owner    <= w_owner_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      w_state_nxt    = r_state;
      w_owner_nxt    = r_owner;
      w_beat_cnt_nxt = r_beat_cnt;
      if (w_xfer) begin
         if (r_state == BURST && w_sel == r_owner) begin
            w_beat_cnt_nxt = r_beat_cnt + CW'(1);
         end else begin
            w_owner_nxt    = w_sel;
            w_beat_cnt_nxt = CW'(1);
            w_state_nxt    = BURST;
         end
         if (w_beat_cnt_nxt == BL) w_state_nxt = IDLE;
      end else if (r_state == BURST && !bus.ch_valid_i[r_owner] && w_slot_free) begin
         // Owner went quiet with room downstream and nobody else asked:
         // close the burst so a later request starts a fresh one.
         w_state_nxt = IDLE;
      end
   end

   // FSM: outputs
   always_comb begin
      w_ch_ready = '0;
      if (w_grant && w_slot_free && !rst_i && !clr_i)
         w_ch_ready[w_sel] = 1'b1;
      busy_o = (r_state == BURST) || r_out_valid;
   end

   // One-entry output stage
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_id    <= '0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= bus.ch_data_i[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
         r_out_id    <= w_sel;
      end else if (bus.out_ready_i) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.ch_ready_o  = w_ch_ready;
   assign bus.out_valid_o = r_out_valid;
   assign bus.out_data_o  = r_out_data;
   assign bus.out_id_o    = r_out_id;
endmodule

// File: tb/tb_io_fifo_rr_arbiter.sv
module tb_io_fifo_rr_arbiter;
   localparam int N  = 4;
   localparam int DW = 32;

   typedef struct {
      logic         clr;
      logic [N-1:0] valid;
      logic         rdy;
      logic [N-1:0] exp_rdy;
   } vec_t;

   typedef struct {
      logic [1:0]    id;
      logic [DW-1:0] data;
   } word_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clr = 1'b0;
   logic busy;

   io_fifo_rr_arbiter_if #(.N_CH(N), .DATA_WIDTH(DW)) bus();

   io_fifo_rr_arbiter #(.N_CH(N), .DATA_WIDTH(DW), .BURST_LEN(4)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .clr_i  (clr),
      .busy_o (busy),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int    nvec = 0;
   int    nfail = 0;
   int    tick = 0;
   logic  exp_valid = 1'b0;
   word_t sb[$];
   vec_t  vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic c, input logic [N-1:0] v, input logic r, input logic [N-1:0] e, input int n);
      vec_t x;
      x.clr = c; x.valid = v; x.rdy = r; x.exp_rdy = e;
      for (int i = 0; i < n; i++) vecs.push_back(x);
   endtask

   function automatic logic [1:0] oh2id(input logic [N-1:0] oh);
      logic [1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) if (oh[i]) r = 2'(i);
      return r;
   endfunction

   function automatic logic [DW-1:0] mkdata(input int ch, input int t);
      return {8'(ch), 24'(t)};
   endfunction

   task automatic step(input vec_t v);
      word_t w;
      tick++;
      bus.ch_valid_i  = v.valid;
      bus.out_ready_i = v.rdy;
      clr             = v.clr;
      for (int k = 0; k < N; k++) bus.ch_data_i[k*DW +: DW] = mkdata(k, tick);
      @(negedge clk);
      chk("ch_ready", 64'(bus.ch_ready_o), 64'(v.exp_rdy));
      chk("out_valid", 64'(bus.out_valid_o), 64'(exp_valid));
      if (exp_valid) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 64'(1), 64'(0));
         end else begin
            chk("out_id", 64'(bus.out_id_o), 64'(sb[0].id));
            chk("out_data", 64'(bus.out_data_o), 64'(sb[0].data));
            if (v.rdy) void'(sb.pop_front());
         end
      end
      if (v.clr) begin
         sb.delete();
         exp_valid = 1'b0;
      end else if (v.exp_rdy != '0) begin
         w.id   = oh2id(v.exp_rdy);
         w.data = mkdata(int'(w.id), tick);
         sb.push_back(w);
         exp_valid = 1'b1;
      end else if (v.rdy) begin
         exp_valid = 1'b0;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      // T1 first grant after reset
      add(0, 4'b0001, 1, 4'b0001, 1);
      // T2 single stream on ch2, burst restarts after beat 4
      add(0, 4'b0100, 1, 4'b0100, 6);
      add(1, 4'b1111, 1, 4'b0000, 1);
      // T3 full contention: 0x4,1x4,2x4,3x4,0
      add(0, 4'b1111, 1, 4'b0001, 4);
      add(0, 4'b1111, 1, 4'b0010, 4);
      add(0, 4'b1111, 1, 4'b0100, 4);
      add(0, 4'b1111, 1, 4'b1000, 4);
      add(0, 4'b1111, 1, 4'b0001, 1);
      // T4 backpressure, request vector changes while stalled
      add(0, 4'b1111, 0, 4'b0000, 1);
      add(0, 4'b0010, 0, 4'b0000, 1);
      add(0, 4'b1111, 0, 4'b0000, 1);
      add(0, 4'b1111, 1, 4'b0001, 3);
      add(0, 4'b1111, 1, 4'b0010, 1);
      // T5 ch1 drops after 2 beats: 3,3,3,3 then 0
      add(0, 4'b1111, 1, 4'b0010, 1);
      add(0, 4'b1001, 1, 4'b1000, 4);
      add(0, 4'b1001, 1, 4'b0001, 1);
      // T6 clr with owner ch2, beat_cnt 2; next grant ch0
      add(0, 4'b0100, 1, 4'b0100, 2);
      add(1, 4'b1111, 1, 4'b0000, 1);
      add(0, 4'b1111, 1, 4'b0001, 1);
      // drain
      add(0, 4'b0000, 1, 4'b0000, 2);

      // reset for 2 cycles, requests present during reset must not be accepted
      bus.ch_valid_i  = '0;
      bus.out_ready_i = 1'b1;
      bus.ch_data_i   = '0;
      @(posedge clk); #1;
      bus.ch_valid_i = 4'b1111;
      #1;
      chk("rst_ch_ready", 64'(bus.ch_ready_o), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      bus.ch_valid_i = '0;
      #1;
      chk("rst_out_valid", 64'(bus.out_valid_o), 64'(0));
      chk("rst_out_data", 64'(bus.out_data_o), 64'(0));
      chk("rst_out_id", 64'(bus.out_id_o), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_idle_ready", 64'(bus.ch_ready_o), 64'(0));

      foreach (vecs[i]) step(vecs[i]);

      chk("sb_empty", 64'(sb.size()), 64'(0));
      chk("end_busy_out", 64'(bus.out_valid_o), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
